// File: rtl/sipo_rx_if.sv
// Handshake bundle for the serial-in/parallel-out receiver.
// The serial line and strobe come from the master; the received word goes back to it.
interface sipo_rx_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_en;
    logic             dout_ack;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        output sin, sin_en, dout_ack,
        input  dout, dout_valid, busy, frame_err, overrun
    );

    modport slave (
        input  sin, sin_en, dout_ack,
        output dout, dout_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/sipo_rx.sv
// Strobed serial receiver: start bit 0, WIDTH data bits LSB-first, stop bit 1.
// Holds the last good word until acknowledged; flags framing errors and overruns.
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    sipo_rx_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("sipo_rx: WIDTH must be in 2..16");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               dout_valid_q, dout_valid_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               load;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        frame_err_d  = 1'b0;
        load         = 1'b0;

        if (bus.sin_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!bus.sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {bus.sin, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // Either way we go back to IDLE; a bad stop bit must not count as a start bit.
                    state_d = IDLE;
                    if (bus.sin) begin
                        load = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        shift_d     = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // Output word and its handshake; a load wins over a simultaneous acknowledge.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = 1'b0;

        if (load) begin
            dout_d       = shift_q;
            dout_valid_d = 1'b1;
            overrun_d    = dout_valid_q && !bus.dout_ack;
        end else if (bus.dout_ack) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter WIDTH, default 4: number of data bits per frame; legal range 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted); one clock, no other clock domains.
REQ-004 sin  input  1  serial line; idle level 1.
REQ-005 sin_en  input  1  bit strobe; sin is sampled only on rising clk edges where sin_en=1.
REQ-006 dout_ack  input  1  consumer acknowledge of dout.
REQ-007 dout  output  WIDTH  last received word, registered.
REQ-008 dout_valid  output  1  dout holds an unacknowledged word.
REQ-009 busy  output  1  high while in DATA or STOP state.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-011 overrun  output  1  one-cycle pulse: a new word overwrote an unacknowledged word.

Function
REQ-012 The frame format SHALL be: start bit 0, then WIDTH data bits LSB-first, then stop bit 1, one bit per sin_en strobe.
REQ-013 The FSM SHALL have states IDLE, DATA and STOP; cycles with sin_en=0 SHALL cause no state, counter or shift change.
REQ-014 IDLE: on strobe with sin=0 -> DATA with bit counter cleared; on strobe with sin=1 -> stay in IDLE.
REQ-015 DATA: each strobe SHALL shift sin into the MSB of a WIDTH-bit shift register (right shift) and increment the counter; on the WIDTH-th strobe -> STOP.
REQ-016 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within a frame.
REQ-017 STOP, strobe with sin=1: dout <= shift register, dout_valid <= 1, -> IDLE; the outputs update on that same edge (visible the cycle after the stop-bit strobe).
REQ-018 STOP, strobe with sin=0: frame_err pulses for one cycle, dout and dout_valid are unchanged, shift register is discarded, -> IDLE.
REQ-019 After a framing error, the next start bit SHALL be recognised only on a later strobe; the bad stop bit is never treated as a start bit.
REQ-020 dout_valid SHALL clear on the edge where dout_ack=1, unless a new word loads on that same edge.
REQ-021 New word loads while dout_valid=1 and dout_ack=0: dout SHALL be overwritten, dout_valid SHALL stay 1, and overrun SHALL pulse for one cycle.
REQ-022 New word loads on the same edge as dout_ack=1: dout SHALL be overwritten, dout_valid SHALL stay 1, and no overrun SHALL occur.
REQ-023 dout_ack while dout_valid=0 SHALL be ignored.
REQ-024 busy SHALL be a registered decode: 1 in DATA/STOP, 0 in IDLE.
REQ-025 The block SHALL accept back-to-back frames: a start bit on the strobe immediately after the stop-bit strobe SHALL be accepted.

Reset
REQ-026 reset=0 SHALL immediately (asynchronously) force state=IDLE, counter=0, shift=0, dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word; after reset release the receiver SHALL wait for a new start bit.
REQ-028 Reset release SHALL take effect on the first rising clk after reset goes high; no strobe is sampled while reset=0.

Verification
REQ-029 WIDTH=4, strobe every cycle, sin=0,0,1,0,1,1 (start, data LSB-first, stop) -> dout=4'b1010, dout_valid=1 one cycle after the stop strobe, frame_err=0.
REQ-030 Same frame with the stop bit sin=0 -> frame_err pulses once; dout and dout_valid keep their prior values (0/0 after reset); busy returns to 0.
REQ-031 Two frames 4'b1010 then 4'b0101, dout_ack held 0 -> dout=4'b0101, dout_valid=1, overrun pulses once; repeat with dout_ack=1 on the second load edge -> no overrun.
REQ-032 sin_en strobing every 3rd cycle with sin toggling on non-strobe cycles -> the same dout as REQ-029 (non-strobe values ignored).
REQ-033 reset driven 0 asynchronously (between clk edges) after 2 data bits, then released, then a full frame 4'b1100 is sent -> all outputs 0 during reset; afterwards dout=4'b1100 with no framing error.
REQ-034 Idle line (sin=1) with continuous strobes for 20 cycles -> busy=0, dout_valid=0, no pulses on frame_err or overrun.
